// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot/index grant and a hold
// timeout; the index output drives the select lines of a downstream 3-to-8 decoder.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    localparam bit         HOLD_EN  = (HOLD_MAX != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [7:0] cnt_q;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       vld_q;
    logic       to_q;

    logic       sel_any_d;
    logic [2:0] sel_idx_d;
    logic [2:0] cand;

    // Walk offsets from high to low so the requester closest to ptr_q wins.
    always_comb begin
        sel_any_d = 1'b0;
        sel_idx_d = 3'd0;
        cand      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                sel_any_d = 1'b1;
                sel_idx_d = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            to_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && sel_any_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 8'b1 << sel_idx_d;
                        idx_q   <= sel_idx_d;
                        vld_q   <= 1'b1;
                        cnt_q   <= 8'd1;
                        ptr_q   <= sel_idx_d + 3'd1;
                    end
                end
                GRANT: begin
                    // A release in the timeout cycle wins over the forced release.
                    if (!req[idx_q] || (HOLD_EN && cnt_q == HOLD_LIM)) begin
                        state_q <= IDLE;
                        gnt_q   <= 8'h00;
                        idx_q   <= 3'd0;
                        vld_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        to_q    <= req[idx_q];
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed per-cycle stimulus queues the
// expected registered outputs, and an independent monitor pops and compares them.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter_8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per clock edge, checked 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.g, e.i, e.v, e.t}) begin
                    bad++;
                    $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                             e.tag, gnt, gnt_idx, gnt_valid, timeout, e.g, e.i, e.v, e.t);
                end
            end
        end
    end

    // Apply inputs for one cycle and queue the outputs expected after the next edge.
    task automatic cyc(input logic [7:0] r, input logic e_en, input logic ev,
                       input logic [2:0] ei, input logic et, input string tag);
        exp_t e;
        req   = r;
        en    = e_en;
        e.v   = ev;
        e.i   = ev ? ei : 3'd0;
        e.g   = ev ? (8'b1 << ei) : 8'h00;
        e.t   = et;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        total++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
            bad++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want all zero",
                     tag, gnt, gnt_idx, gnt_valid, timeout);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        #1;
        check_idle("reset_state");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single requester 5, held three cycles.
        cyc(8'h20, 1'b1, 1'b1, 3'd5, 1'b0, "single_grant");
        cyc(8'h20, 1'b1, 1'b1, 3'd5, 1'b0, "single_hold1");
        cyc(8'h20, 1'b1, 1'b1, 3'd5, 1'b0, "single_hold2");
        cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "single_release");
        cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "single_idle");

        // Wrap and skip with ptr at 6.
        cyc(8'h03, 1'b1, 1'b1, 3'd0, 1'b0, "wrap_grant0");
        cyc(8'h02, 1'b1, 1'b0, 3'd0, 1'b0, "wrap_release0");
        cyc(8'h03, 1'b1, 1'b1, 3'd1, 1'b0, "wrap_grant1");
        cyc(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, "wrap_release1");
        cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "wrap_idle");

        // Grant 2 active (ptr at 2), then asynchronous reset mid-grant.
        cyc(8'hFF, 1'b1, 1'b1, 3'd2, 1'b0, "pre_rst_grant");
        cyc(8'hFF, 1'b1, 1'b1, 3'd2, 1'b0, "pre_rst_hold");
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(posedge clk);
        #1;
        check_idle("reset_held");
        #1;
        rst = 1'b0;

        // Rotation from ptr 0 with each owner dropping its bit for one cycle.
        for (int k = 0; k < 8; k++) begin
            cyc(8'hFF, 1'b1, 1'b1, 3'(k), 1'b0, $sformatf("rot_grant%0d", k));
            cyc(8'hFF & ~(8'b1 << k), 1'b1, 1'b0, 3'd0, 1'b0, $sformatf("rot_gap%0d", k));
        end
        cyc(8'hFF, 1'b1, 1'b1, 3'd0, 1'b0, "rot_wrap0");
        cyc(8'hFE, 1'b1, 1'b0, 3'd0, 1'b0, "rot_wrap_gap");

        // Timeout with HOLD_MAX=4 on requester 2 (ptr at 1).
        cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b0, "to_grant");
        cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b0, "to_hold2");
        cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b0, "to_hold3");
        cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b0, "to_hold4");
        cyc(8'h04, 1'b1, 1'b0, 3'd0, 1'b1, "to_pulse");
        cyc(8'h0C, 1'b1, 1'b1, 3'd3, 1'b0, "to_next3");
        cyc(8'h04, 1'b1, 1'b0, 3'd0, 1'b0, "to_rel3");
        cyc(8'h04, 1'b1, 1'b1, 3'd2, 1'b0, "to_regrant2");
        cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "to_rel2");

        // Release in the same cycle the counter reaches HOLD_MAX: no pulse.
        cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b0, "edge_grant");
        cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b0, "edge_hold2");
        cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b0, "edge_hold3");
        cyc(8'h08, 1'b1, 1'b1, 3'd3, 1'b0, "edge_hold4");
        cyc(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "edge_release");

        // Enable gating on requester 4 (ptr at 4).
        cyc(8'h10, 1'b0, 1'b0, 3'd0, 1'b0, "en_block1");
        cyc(8'h10, 1'b0, 1'b0, 3'd0, 1'b0, "en_block2");
        cyc(8'h10, 1'b1, 1'b1, 3'd4, 1'b0, "en_grant");
        cyc(8'h10, 1'b0, 1'b1, 3'd4, 1'b0, "en_drop_hold1");
        cyc(8'h10, 1'b0, 1'b1, 3'd4, 1'b0, "en_drop_hold2");
        cyc(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "en_release");

        repeat (4) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
